gate_unit_scheduler: RTL

- Time-shares one 1-bit NAND-built logic unit (NOT/AND/OR/XOR, using the team's gate library) between NREQ requesters.
- Each requester submits a WIDTH-bit operation. The block arbitrates round-robin, latches the operands, evaluates them bit-serially LSB-first, and returns the result with a one-cycle done pulse.
- Sits between client FSMs and the shared gate datapath.

---
 rtl/gate_unit_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gate_unit_scheduler.sv
// Round-robin scheduler sharing one bit-serial NAND-built logic unit (NOT/AND/OR/XOR) between NREQ clients.
// Grant in cycle n, done pulse in cycle n+WIDTH; requests are only sampled in IDLE, so clients simply wait.
module gate_unit_scheduler #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op_i,
    input  logic [WIDTH*NREQ-1:0]   a_i,
    input  logic [WIDTH*NREQ-1:0]   b_i,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result
);

    localparam int IW = (NREQ  > 1) ? $clog2(NREQ)  : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, sr_q, result_q, word_d;
    logic [CW-1:0]      cnt_q;
    logic [NREQ-1:0]    gnt_q, gnt_d, done_q, done_d;
    logic               busy_q, busy_d;
    logic [IW-1:0]      sel;
    logic               found;
    logic               abit, bbit, ubit, last_bit;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // Circular search starting just above the last winner.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last_q) + k) % NREQ]) begin
                found = 1'b1;
                sel   = IW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // Shared 1-bit unit, every function composed from 2-input NANDs.
    assign abit     = a_q[cnt_q];
    assign bbit     = b_q[cnt_q];
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        ubit = 1'b0;
        case (op_q)
            2'b00: ubit = nand2(abit, abit);
            2'b01: ubit = nand2(nand2(abit, bbit), nand2(abit, bbit));
            2'b10: ubit = nand2(nand2(abit, abit), nand2(bbit, bbit));
            2'b11: ubit = nand2(nand2(abit, nand2(abit, bbit)),
                                nand2(bbit, nand2(abit, bbit)));
            default: ubit = 1'b0;
        endcase
    end

    always_comb begin
        word_d         = sr_q;
        word_d[cnt_q]  = ubit;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        if (state_q == S_IDLE && found) gnt_d = ONE << sel;
        if (state_q == S_RUN && last_bit) done_d = ONE << last_q;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= IW'(NREQ - 1);
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        last_q <= sel;
                        op_q   <= op_i[2*sel +: 2];
                        a_q    <= a_i[WIDTH*sel +: WIDTH];
                        b_q    <= b_i[WIDTH*sel +: WIDTH];
                        cnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    sr_q  <= word_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) result_q <= word_d;
                end
                default: ;
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign result = result_q;

endmodule
